// File: rtl/cdb_arbiter_if.sv
// Result-pipe and CDB bundle for cdb_arbiter: three producer pipes, branch
// squash/resolve controls, per-pipe ready, the registered broadcast and the sticky error.
interface cdb_arbiter_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PRN_W   = 6,
  parameter int unsigned ROB_W   = 5,
  parameter int unsigned BMASK_W = 8
);
  logic               alu_valid, ld_valid, mul_valid;
  logic [XLEN-1:0]    alu_data, ld_data, mul_data;
  logic [PRN_W-1:0]   alu_tag, ld_tag, mul_tag;
  logic [ROB_W-1:0]   alu_rob_idx, ld_rob_idx, mul_rob_idx;
  logic [BMASK_W-1:0] alu_bmask, ld_bmask, mul_bmask;
  logic               squash_valid, resolve_valid;
  logic [BMASK_W-1:0] squash_mask, resolve_mask;
  logic               alu_ready, ld_ready, mul_ready;
  logic               cdb_valid;
  logic [XLEN-1:0]    cdb_data;
  logic [PRN_W-1:0]   cdb_tag;
  logic [ROB_W-1:0]   cdb_rob_idx;
  logic [BMASK_W-1:0] cdb_bmask;
  logic               overflow_err;

  modport master (
    output alu_valid, ld_valid, mul_valid, alu_data, ld_data, mul_data,
           alu_tag, ld_tag, mul_tag, alu_rob_idx, ld_rob_idx, mul_rob_idx,
           alu_bmask, ld_bmask, mul_bmask,
           squash_valid, squash_mask, resolve_valid, resolve_mask,
    input  alu_ready, ld_ready, mul_ready,
           cdb_valid, cdb_data, cdb_tag, cdb_rob_idx, cdb_bmask, overflow_err
  );

  modport slave (
    input  alu_valid, ld_valid, mul_valid, alu_data, ld_data, mul_data,
           alu_tag, ld_tag, mul_tag, alu_rob_idx, ld_rob_idx, mul_rob_idx,
           alu_bmask, ld_bmask, mul_bmask,
           squash_valid, squash_mask, resolve_valid, resolve_mask,
    output alu_ready, ld_ready, mul_ready,
           cdb_valid, cdb_data, cdb_tag, cdb_rob_idx, cdb_bmask, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-pipe result FIFOs with bypass, fixed priority
// mul > ld > alu onto a registered CDB, with branch squash/resolve on buffered results.
module cdb_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PRN_W     = 6,
  parameter int unsigned ROB_W     = 5,
  parameter int unsigned BMASK_W   = 8,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned NSRC  = 3;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [PRN_W-1:0]   tag;
    logic [ROB_W-1:0]   rob;
    logic [BMASK_W-1:0] bmask;
  } pkt_t;

  function automatic logic hit(input pkt_t p, input logic [BMASK_W-1:0] m);
    return |(p.bmask & m);
  endfunction

  function automatic pkt_t clr(input pkt_t p, input logic [BMASK_W-1:0] m);
    pkt_t o;
    o       = p;
    o.bmask = p.bmask & ~m;
    return o;
  endfunction

  pkt_t             r_q     [NSRC][BUF_DEPTH];
  logic [CNT_W-1:0] r_cnt   [NSRC];
  logic             r_cdb_valid;
  pkt_t             r_cdb;
  logic             r_ovf;

  pkt_t             w_nxt_q   [NSRC][BUF_DEPTH];
  logic [CNT_W-1:0] w_nxt_cnt [NSRC];
  pkt_t             w_in      [NSRC];
  pkt_t             w_cand    [NSRC];
  logic [NSRC-1:0]  w_in_vld, w_rdy, w_cand_fifo, w_elig, w_grant;
  logic [BMASK_W-1:0] w_kill, w_res;
  pkt_t             w_win;
  logic             w_win_vld;
  logic             w_ovf_set;

  always_comb begin
    w_in_vld = {bus.mul_valid, bus.ld_valid, bus.alu_valid};
    w_in[0]  = {bus.alu_data, bus.alu_tag, bus.alu_rob_idx, bus.alu_bmask};
    w_in[1]  = {bus.ld_data,  bus.ld_tag,  bus.ld_rob_idx,  bus.ld_bmask};
    w_in[2]  = {bus.mul_data, bus.mul_tag, bus.mul_rob_idx, bus.mul_bmask};
    w_kill   = bus.squash_valid  ? bus.squash_mask  : '0;
    w_res    = bus.resolve_valid ? bus.resolve_mask : '0;
  end

  // A non-empty FIFO always offers its head; the live input only bypasses an empty FIFO.
  always_comb begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      w_rdy[s]       = r_cnt[s] < CNT_W'(BUF_DEPTH);
      w_cand_fifo[s] = (r_cnt[s] != '0);
      w_cand[s]      = w_cand_fifo[s] ? r_q[s][0] : w_in[s];
      w_elig[s]      = (w_cand_fifo[s] || w_in_vld[s]) && !hit(w_cand[s], w_kill);
    end
    w_grant = '0;
    if (w_elig[2])      w_grant[2] = 1'b1;
    else if (w_elig[1]) w_grant[1] = 1'b1;
    else if (w_elig[0]) w_grant[0] = 1'b1;
    w_win_vld = |w_elig;
    w_win     = '0;
    for (int unsigned s = 0; s < NSRC; s++)
      if (w_grant[s]) w_win = w_cand[s];
  end

  // Rebuild each FIFO head-aligned: drop the popped head and squashed entries
  // (order kept), clear resolved bits, then append the accepted input.
  always_comb begin
    int unsigned k;
    k         = 0;
    w_ovf_set = 1'b0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      k = 0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) w_nxt_q[s][i] = '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        if ((CNT_W'(i) < r_cnt[s]) && !(i == 0 && w_grant[s] && w_cand_fifo[s])
            && !hit(r_q[s][i], w_kill)) begin
          w_nxt_q[s][k[IDX_W-1:0]] = clr(r_q[s][i], w_res);
          k++;
        end
      end
      if (w_in_vld[s] && w_rdy[s] && !hit(w_in[s], w_kill)
          && !(w_grant[s] && !w_cand_fifo[s]) && k < BUF_DEPTH) begin
        w_nxt_q[s][k[IDX_W-1:0]] = clr(w_in[s], w_res);
        k++;
      end
      w_nxt_cnt[s] = CNT_W'(k);
      if (w_in_vld[s] && !w_rdy[s]) w_ovf_set = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        r_cnt[s] <= '0;
        for (int unsigned i = 0; i < BUF_DEPTH; i++) r_q[s][i] <= '0;
      end
      r_cdb_valid <= 1'b0;
      r_cdb       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        r_cnt[s] <= w_nxt_cnt[s];
        for (int unsigned i = 0; i < BUF_DEPTH; i++) r_q[s][i] <= w_nxt_q[s][i];
      end
      r_cdb_valid <= w_win_vld;
      r_cdb       <= w_win_vld ? clr(w_win, w_res) : '0;
      r_ovf       <= r_ovf | w_ovf_set;
    end
  end

  assign bus.alu_ready    = w_rdy[0];
  assign bus.ld_ready     = w_rdy[1];
  assign bus.mul_ready    = w_rdy[2];
  assign bus.cdb_valid    = r_cdb_valid;
  assign bus.cdb_data     = r_cdb.data;
  assign bus.cdb_tag      = r_cdb.tag;
  assign bus.cdb_rob_idx  = r_cdb.rob;
  assign bus.cdb_bmask    = r_cdb.bmask;
  assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
    logic [4:0]  rob;
    logic [7:0]  bmask;
  } pkt_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.XLEN(32), .PRN_W(6), .ROB_W(5), .BMASK_W(8)) bus ();

  cdb_arbiter #(.XLEN(32), .PRN_W(6), .ROB_W(5), .BMASK_W(8), .BUF_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus for the next cycle: index 0=alu, 1=ld, 2=mul
  pkt_t       in_p [3];
  logic       in_v [3];
  logic       rst, sq_v, rs_v;
  logic [7:0] sq_m, rs_m;

  pkt_t mq [3][$];
  logic exp_valid, exp_ovf;
  pkt_t exp_pkt;
  logic exp_rdy [3];

  int vectors = 0;
  int miscompares = 0;

  task automatic clear_in();
    for (int s = 0; s < 3; s++) begin in_v[s] = 1'b0; in_p[s] = '0; end
    rst = 1'b0; sq_v = 1'b0; rs_v = 1'b0; sq_m = '0; rs_m = '0;
  endtask

  task automatic model_step();
    pkt_t cand [3];
    bit   from_q [3], cv [3], rdy0 [3];
    int   win;
    logic [7:0] kill, rclr;
    pkt_t keep [$];
    pkt_t p;
    if (rst) begin
      for (int s = 0; s < 3; s++) begin mq[s].delete(); exp_rdy[s] = 1'b1; end
      exp_valid = 1'b0; exp_pkt = '0; exp_ovf = 1'b0;
      return;
    end
    kill = sq_v ? sq_m : 8'h00;
    rclr = rs_v ? rs_m : 8'h00;
    for (int s = 0; s < 3; s++) begin
      rdy0[s] = mq[s].size() < DEPTH;
      if (mq[s].size() > 0) begin cand[s] = mq[s][0]; from_q[s] = 1; cv[s] = 1; end
      else begin cand[s] = in_p[s]; from_q[s] = 0; cv[s] = in_v[s]; end
    end
    win = -1;
    for (int s = 2; s >= 0; s--)
      if (win < 0 && cv[s] && (cand[s].bmask & kill) == 8'h00) win = s;
    exp_valid = (win >= 0);
    exp_pkt = '0;
    if (win >= 0) begin exp_pkt = cand[win]; exp_pkt.bmask = exp_pkt.bmask & ~rclr; end
    for (int s = 0; s < 3; s++) begin
      if (win == s && from_q[s]) void'(mq[s].pop_front());
      keep.delete();
      for (int i = 0; i < mq[s].size(); i++)
        if ((mq[s][i].bmask & kill) == 8'h00) begin
          p = mq[s][i]; p.bmask = p.bmask & ~rclr; keep.push_back(p);
        end
      mq[s] = keep;
      if (in_v[s]) begin
        if (!rdy0[s]) exp_ovf = 1'b1;
        else if ((in_p[s].bmask & kill) == 8'h00 && !(win == s && !from_q[s])) begin
          p = in_p[s]; p.bmask = p.bmask & ~rclr; mq[s].push_back(p);
        end
      end
      exp_rdy[s] = mq[s].size() < DEPTH;
    end
  endtask

  task automatic tick();
    bus.alu_valid = in_v[0]; bus.alu_data = in_p[0].data; bus.alu_tag = in_p[0].tag;
    bus.alu_rob_idx = in_p[0].rob; bus.alu_bmask = in_p[0].bmask;
    bus.ld_valid = in_v[1]; bus.ld_data = in_p[1].data; bus.ld_tag = in_p[1].tag;
    bus.ld_rob_idx = in_p[1].rob; bus.ld_bmask = in_p[1].bmask;
    bus.mul_valid = in_v[2]; bus.mul_data = in_p[2].data; bus.mul_tag = in_p[2].tag;
    bus.mul_rob_idx = in_p[2].rob; bus.mul_bmask = in_p[2].bmask;
    bus.squash_valid = sq_v; bus.squash_mask = sq_m;
    bus.resolve_valid = rs_v; bus.resolve_mask = rs_m;
    reset = rst;
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_in(); rst = 1'b1;
    tick(); tick();
    clear_in();
    vectors++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_data !== 32'h0 || bus.cdb_tag !== 6'd0 ||
        bus.cdb_rob_idx !== 5'd0 || bus.cdb_bmask !== 8'h00 || bus.alu_ready !== 1'b1 ||
        bus.ld_ready !== 1'b1 || bus.mul_ready !== 1'b1 || bus.overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b data=%h rdy=%b%b%b ovf=%b, want 0/0/111/0",
               bus.cdb_valid, bus.cdb_data, bus.mul_ready, bus.ld_ready, bus.alu_ready, bus.overflow_err);
    end
  endtask

  task automatic test_single();
    clear_in();
    in_v[0] = 1'b1; in_p[0] = '{32'h3E8, 6'd10, 5'd3, 8'h00};
    tick(); clear_in();
    vectors++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'h3E8 || bus.cdb_tag !== 6'd10 ||
        bus.cdb_rob_idx !== 5'd3) begin
      miscompares++;
      $display("FAIL single_k1: valid=%b data=%h tag=%0d rob=%0d, want 1/3e8/10/3",
               bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_rob_idx);
    end
    tick();
    vectors++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_data !== 32'h0) begin
      miscompares++;
      $display("FAIL single_k2: valid=%b data=%h, want 0/0", bus.cdb_valid, bus.cdb_data);
    end
  endtask

  task automatic test_collision();
    logic [31:0] want [3];
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33;
    clear_in();
    in_v[2] = 1; in_p[2] = '{32'h11, 6'd1, 5'd1, 8'h00};
    in_v[1] = 1; in_p[1] = '{32'h22, 6'd2, 5'd2, 8'h00};
    in_v[0] = 1; in_p[0] = '{32'h33, 6'd3, 5'd3, 8'h00};
    tick(); clear_in();
    vectors++;
    if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1 || bus.mul_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_ready: rdy=%b%b%b, want 111", bus.mul_ready, bus.ld_ready, bus.alu_ready);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== want[c]) begin
        miscompares++;
        $display("FAIL collide_k%0d: valid=%b data=%h, want 1/%h", c + 1, bus.cdb_valid, bus.cdb_data, want[c]);
      end
      tick();
    end
    vectors++;
    if (bus.cdb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_idle: valid=%b, want 0", bus.cdb_valid);
    end
  endtask

  task automatic test_fill_overflow();
    logic rdy_seen [3];
    clear_in();
    for (int c = 0; c < 3; c++) begin
      in_v[2] = 1; in_p[2] = '{32'h900 + c, 6'd9, 5'd9, 8'h00};
      in_v[0] = 1; in_p[0] = '{32'hA00 + c, 6'd20, 5'(c), 8'h00};
      tick();
      rdy_seen[c] = bus.alu_ready;
    end
    clear_in();
    vectors++;
    if (rdy_seen[0] !== 1'b1 || rdy_seen[1] !== 1'b0 || rdy_seen[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_ready: alu_ready seq=%b%b%b, want 100", rdy_seen[0], rdy_seen[1], rdy_seen[2]);
    end
    vectors++;
    if (bus.overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_overflow: overflow_err=%b, want 1", bus.overflow_err);
    end
    tick();
    vectors++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'hA00) begin
      miscompares++;
      $display("FAIL fill_drain0: valid=%b data=%h, want 1/a00", bus.cdb_valid, bus.cdb_data);
    end
    tick();
    vectors++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'hA01) begin
      miscompares++;
      $display("FAIL fill_drain1: valid=%b data=%h, want 1/a01", bus.cdb_valid, bus.cdb_data);
    end
    tick();
    vectors++;
    if (bus.cdb_valid !== 1'b0 || bus.overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_dropped: valid=%b data=%h ovf=%b, want 0/-/1", bus.cdb_valid, bus.cdb_data, bus.overflow_err);
    end
  endtask

  task automatic test_squash();
    clear_in();
    in_v[2] = 1; in_p[2] = '{32'h55, 6'd5, 5'd5, 8'h00};
    in_v[0] = 1; in_p[0] = '{32'hA80, 6'd11, 5'd11, 8'h80};
    tick();
    in_p[0] = '{32'hA01, 6'd12, 5'd12, 8'h01};
    tick(); clear_in();
    vectors++;
    if (bus.alu_ready !== 1'b0 || bus.cdb_data !== 32'h55) begin
      miscompares++;
      $display("FAIL squash_setup: alu_ready=%b data=%h, want 0/55", bus.alu_ready, bus.cdb_data);
    end
    sq_v = 1; sq_m = 8'h80;
    tick(); clear_in();
    vectors++;
    if (bus.alu_ready !== 1'b1 || bus.cdb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL squash_edge: alu_ready=%b valid=%b, want 1/0", bus.alu_ready, bus.cdb_valid);
    end
    tick();
    vectors++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'hA01 || bus.cdb_bmask !== 8'h01) begin
      miscompares++;
      $display("FAIL squash_survivor: valid=%b data=%h bmask=%h, want 1/a01/01",
               bus.cdb_valid, bus.cdb_data, bus.cdb_bmask);
    end
    tick();
    vectors++;
    if (bus.cdb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL squash_after: valid=%b data=%h, want 0", bus.cdb_valid, bus.cdb_data);
    end
  endtask

  task automatic test_resolve_squash();
    clear_in();
    in_v[2] = 1; in_p[2] = '{32'h66, 6'd6, 5'd6, 8'h00};
    in_v[0] = 1; in_p[0] = '{32'hAC0, 6'd13, 5'd13, 8'hC0};
    in_v[1] = 1; in_p[1] = '{32'hB80, 6'd14, 5'd14, 8'h80};
    tick();
    in_v[1] = 0;
    in_p[0] = '{32'hA40, 6'd15, 5'd15, 8'h40};
    tick(); clear_in();
    rs_v = 1; rs_m = 8'h80; sq_v = 1; sq_m = 8'h40;
    tick(); clear_in();
    vectors++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'hB80 || bus.cdb_bmask !== 8'h00 ||
        bus.alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rsq_bcast: valid=%b data=%h bmask=%h alu_ready=%b, want 1/b80/00/1",
               bus.cdb_valid, bus.cdb_data, bus.cdb_bmask, bus.alu_ready);
    end
    tick();
    vectors++;
    if (bus.cdb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsq_killed: valid=%b data=%h, want 0", bus.cdb_valid, bus.cdb_data);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    clear_in();
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) begin
        in_v[s] = 1; in_p[s] = '{32'hC00 + 32'(s * 16 + c), 6'(s), 5'(c), 8'h00};
      end
      tick();
    end
    vectors++;
    if (bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_full: ld/alu ready=%b%b, want 00", bus.ld_ready, bus.alu_ready);
    end
    rst = 1;
    tick(); clear_in();
    vectors++;
    if (bus.cdb_valid !== 1'b0 || bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1 ||
        bus.mul_ready !== 1'b1 || bus.overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_edge: valid=%b rdy=%b%b%b ovf=%b, want 0/111/0",
               bus.cdb_valid, bus.mul_ready, bus.ld_ready, bus.alu_ready, bus.overflow_err);
    end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.cdb_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rstmid_quiet: %0d broadcasts after reset, want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [55:0] got, want;
    int bad = 0;
    clear_in(); rst = 1; tick();
    for (int c = 0; c < 3000; c++) begin
      clear_in();
      for (int s = 0; s < 3; s++) begin
        in_v[s] = ($urandom_range(0, 99) < 55);
        in_p[s] = '{32'($urandom), 6'($urandom), 5'($urandom), 8'($urandom_range(0, 15))};
      end
      sq_v = ($urandom_range(0, 99) < 10); sq_m = 8'h01 << $urandom_range(0, 3);
      rs_v = ($urandom_range(0, 99) < 12); rs_m = 8'h01 << $urandom_range(0, 3);
      rst  = ($urandom_range(0, 199) == 0);
      tick();
      got  = {bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_rob_idx, bus.cdb_bmask,
              bus.mul_ready, bus.ld_ready, bus.alu_ready, bus.overflow_err};
      want = {exp_valid, exp_pkt, exp_rdy[2], exp_rdy[1], exp_rdy[0], exp_ovf};
      vectors++;
      if (got !== want) begin
        miscompares++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc %0d: got %h, want %h", c, got, want);
      end
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single();
    test_collision();
    test_fill_overflow();
    test_squash();
    test_resolve_squash();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
